mips_instr_encoder: RTL and testbench
=====================================

Name: mips_instr_encoder

Overview:
- Program loader that turns field-level instruction descriptions into 32-bit MIPS machine words.
- Writes the words sequentially into the single-cycle core's instruction memory.
- Encodes the opcodes and funct codes that the core's control decoders consume: RTYPE, LW, SW, BEQ, ADDI, J.
- Sits between the testbench/host load interface and the imem write port; runs before the core is released from reset.

Parameters:
- ADDR_W, 6, imem word-address width; DEPTH = 2**ADDR_W words.
- BASE_ADDR, 0, first word address written after each load_start.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- load_start  in  1  one-cycle pulse: begin a new program load at BASE_ADDR
- load_end  in  1  one-cycle pulse: close the current load
- in_valid  in  1  instruction fields valid
- in_ready  out  1  encoder accepts fields this cycle
- in_class  in  3  0 RTYPE, 1 LW, 2 SW, 3 BEQ, 4 ADDI, 5 J, 6 ORI (opt), 7 BNE (opt)
- in_func  in  3  RTYPE only: 0 add, 1 sub, 2 and, 3 or, 4 slt, 5-7 illegal
- in_rs, in_rt, in_rd  in  5 each  register fields
- in_imm  in  16  immediate / branch offset
- in_target  in  26  jump target
- imem_we  out  1  instruction-memory write enable
- imem_addr  out  ADDR_W  write word address
- imem_wd  out  32  encoded instruction word
- loaded  out  1  high in DONE
- full  out  1  DEPTH words written since last load_start
- word_count  out  ADDR_W+1  words written since last load_start
- err_illegal  out  1  one-cycle pulse: illegal class/func accepted

Behaviour:
- Reset (async): state IDLE; imem_we=0, imem_addr=BASE_ADDR, imem_wd=0, word_count=0, full=0, loaded=0, err_illegal=0. Any pending write is dropped.
- States and transitions:
  - IDLE: load_start -> LOAD.
  - LOAD: load_end or last word accepted -> DONE.
  - DONE: load_start -> LOAD.
  - load_start in any state: write pointer := BASE_ADDR, word_count := 0, full := 0.
- Handshake:
  - in_ready = (state==LOAD) && !full_pending && !load_start.
  - Transfer occurs on in_valid && in_ready. in_valid may be held; fields are sampled only on transfer.
- Latency: a word accepted in cycle N appears in cycle N+1 as imem_we=1 with imem_addr=pointer and imem_wd=encoded word. The pointer and word_count increment at the end of N+1. imem_we is a single registered pulse per accepted legal word.
- Encoding:
  - RTYPE: {6'b000000, rs, rt, rd, 5'b0, funct}. funct: add 100000, sub 100010, and 100100, or 100101, slt 101010.
  - LW: {100011, rs, rt, imm}. SW: {101011, rs, rt, imm}. BEQ: {000100, rs, rt, imm}. ADDI: {001000, rs, rt, imm}.
  - J: {000010, target}.
  - Unused fields are ignored.
- Illegal input: class 6/7 without the optional feature, or RTYPE with func 5-7.
  - The transfer completes but nothing is written and the pointer does not move.
  - err_illegal pulses in cycle N+1.
- Full:
  - The accept that makes word_count reach DEPTH blocks further accepts (full_pending).
  - In N+1 the write occurs, full=1, and the state moves to DONE.
  - The pointer wraps to BASE_ADDR only via load_start, never silently.
- Simultaneous events:
  - load_end together with a transfer: the word is accepted and written in N+1; DONE is entered in N+1.
  - load_start in LOAD: the restart wins and no transfer occurs that cycle. A write pending from the prior cycle still completes at the old address; then the pointer resets.
  - load_end in IDLE or DONE: ignored.

Optional Feature:
- Macro: ENC_ORI_BNE_EN.
- When defined: class 6 encodes ORI {001101, rs, rt, imm} and class 7 encodes BNE {000101, rs, rt, imm}.
- When undefined: classes 6 and 7 are illegal (err_illegal pulse, no write).

Test Plan:
- Restart and first writes: reset, load_start, send RTYPE add rs=1 rt=2 rd=3, then LW rs=0 rt=4 imm=0x0008 -> imem_we pulses at addr 0 with wd 0x00221820, then at addr 1 with wd 0x8C040008; word_count=2.
- J target 0x0000011 after load_end -> wd 0x08000011 written; loaded=1 one cycle after the write; in_ready=0 in DONE.
- Illegal func: RTYPE func=6 -> no imem_we, err_illegal pulses once, word_count unchanged. Class 7 without ENC_ORI_BNE_EN -> same response; with the macro, BNE rs=1 rt=2 imm=0xFFFF -> wd 0x1422FFFF.
- Fill with ADDR_W=2: stream 5 valid ADDI words -> 4 writes at addresses 0-3; full=1 and in_ready=0 after the 4th accept; DONE entered; 5th word never accepted.
- load_start asserted during a stream with in_valid held high -> no transfer that cycle, pending write completes, next write lands at BASE_ADDR, word_count restarts at 1.
- Reset asserted in the cycle after an accept -> imem_we drops immediately (async), no write occurs, state IDLE, in_ready=0.

Source files
------------

// File: rtl/mips_instr_encoder.sv
// Program loader: field-level instruction descriptions -> MIPS words into imem.
// Define ENC_ORI_BNE_EN to encode class 6 as ORI and class 7 as BNE.
module mips_instr_encoder #(
  parameter int ADDR_W    = 6,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic              load_end,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_class,
  input  logic [2:0]        in_func,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wd,
  output logic              loaded,
  output logic              full,
  output logic [ADDR_W:0]   word_count,
  output logic              err_illegal
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, next_state;

  logic [ADDR_W-1:0] ptr;
  logic              close_pending;
  logic              xfer;
  logic              legal;
  logic              last;
  logic [31:0]       word;
  logic [5:0]        funct;
  logic [ADDR_W+1:0] fill;

  assign in_ready  = (state == LOAD) && !full && !close_pending && !load_start;
  assign xfer      = in_valid && in_ready;
  assign imem_addr = ptr;
  assign loaded    = (state == DONE);

  // count includes a write still in flight this cycle
  assign fill = {1'b0, word_count} + (ADDR_W+2)'(imem_we) + (ADDR_W+2)'(1);
  assign last = (fill == (ADDR_W+2)'(DEPTH));

  always_comb begin
    funct = 6'h00;
    legal = 1'b1;
    case (in_func)
      3'd0:    funct = 6'h20;
      3'd1:    funct = 6'h22;
      3'd2:    funct = 6'h24;
      3'd3:    funct = 6'h25;
      3'd4:    funct = 6'h2a;
      default: legal = 1'b0;
    endcase
    word = 32'h0;
    case (in_class)
      3'd0: word = {6'b000000, in_rs, in_rt, in_rd, 5'b0, funct};
      3'd1: word = {6'b100011, in_rs, in_rt, in_imm};
      3'd2: word = {6'b101011, in_rs, in_rt, in_imm};
      3'd3: word = {6'b000100, in_rs, in_rt, in_imm};
      3'd4: word = {6'b001000, in_rs, in_rt, in_imm};
      3'd5: word = {6'b000010, in_target};
`ifdef ENC_ORI_BNE_EN
      3'd6: word = {6'b001101, in_rs, in_rt, in_imm};
      3'd7: word = {6'b000101, in_rs, in_rt, in_imm};
`else
      default: legal = 1'b0;
`endif
    endcase
    // func only matters for RTYPE
    if (in_class != 3'd0 && in_class <= 3'd5) legal = 1'b1;
`ifdef ENC_ORI_BNE_EN
    if (in_class != 3'd0) legal = 1'b1;
`endif
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (load_start) next_state = LOAD;
      LOAD: begin
        if (load_start)
          next_state = LOAD;
        else if (close_pending || (load_end && !xfer))
          next_state = DONE;
      end
      DONE: if (load_start) next_state = LOAD;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      imem_we       <= 1'b0;
      imem_wd       <= 32'h0;
      err_illegal   <= 1'b0;
      ptr           <= BASE;
      word_count    <= '0;
      full          <= 1'b0;
      close_pending <= 1'b0;
    end else begin
      imem_we     <= xfer && legal;
      err_illegal <= xfer && !legal;
      if (xfer && legal) imem_wd <= word;
      if (load_start) begin
        ptr           <= BASE;
        word_count    <= '0;
        full          <= 1'b0;
        close_pending <= 1'b0;
      end else begin
        if (imem_we) begin
          ptr        <= ptr + 1'b1;
          word_count <= word_count + 1'b1;
        end
        if (xfer && legal && last) full <= 1'b1;
        close_pending <= xfer && (load_end || (legal && last));
      end
    end
  end

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Directed bench for mips_instr_encoder with ADDR_W=2 so fill is reachable.
// Class 7 expectations follow ENC_ORI_BNE_EN.
module tb_mips_instr_encoder;

  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          load_start = 1'b0;
  logic          load_end = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2:0]    in_class = '0;
  logic [2:0]    in_func = '0;
  logic [4:0]    in_rs = '0;
  logic [4:0]    in_rt = '0;
  logic [4:0]    in_rd = '0;
  logic [15:0]   in_imm = '0;
  logic [25:0]   in_target = '0;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wd;
  logic          loaded;
  logic          full;
  logic [AW:0]   word_count;
  logic          err_illegal;

  int checks = 0;
  int errors = 0;

  mips_instr_encoder #(.ADDR_W(AW), .BASE_ADDR(0)) dut (
    .clk(clk), .reset(reset),
    .load_start(load_start), .load_end(load_end),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_class(in_class), .in_func(in_func),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_imm(in_imm), .in_target(in_target),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wd(imem_wd),
    .loaded(loaded), .full(full), .word_count(word_count),
    .err_illegal(err_illegal)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    #2;
    chk("rst_we", 32'(imem_we), 0);
    chk("rst_addr", 32'(imem_addr), 0);
    chk("rst_wd", imem_wd, 0);
    chk("rst_wc", 32'(word_count), 0);
    chk("rst_full", 32'(full), 0);
    chk("rst_loaded", 32'(loaded), 0);
    chk("rst_err", 32'(err_illegal), 0);
    chk("rst_ready", 32'(in_ready), 0);
    step();
    reset = 1'b0;
    step();

    load_start = 1'b1;
    step();
    load_start = 1'b0;
    in_valid = 1'b1;
    in_class = 3'd0; in_func = 3'd0;
    in_rs = 5'd1; in_rt = 5'd2; in_rd = 5'd3;
    #1;
    chk("load_ready", 32'(in_ready), 1);
    step();
    in_class = 3'd1; in_rs = 5'd0; in_rt = 5'd4; in_imm = 16'h0008;
    chk("add_we", 32'(imem_we), 1);
    chk("add_addr", 32'(imem_addr), 0);
    chk("add_wd", imem_wd, 32'h00221820);
    step();
    in_valid = 1'b0;
    chk("lw_we", 32'(imem_we), 1);
    chk("lw_addr", 32'(imem_addr), 1);
    chk("lw_wd", imem_wd, 32'h8C040008);
    chk("lw_wc", 32'(word_count), 1);
    step();
    chk("idle_we", 32'(imem_we), 0);
    chk("two_wc", 32'(word_count), 2);

    in_valid = 1'b1; load_end = 1'b1;
    in_class = 3'd5; in_target = 26'h0000011;
    step();
    in_valid = 1'b0; load_end = 1'b0;
    chk("j_we", 32'(imem_we), 1);
    chk("j_addr", 32'(imem_addr), 2);
    chk("j_wd", imem_wd, 32'h08000011);
    chk("j_loaded_early", 32'(loaded), 0);
    step();
    chk("j_loaded", 32'(loaded), 1);
    chk("j_wc", 32'(word_count), 3);
    chk("done_ready", 32'(in_ready), 0);
    chk("done_we", 32'(imem_we), 0);

    load_start = 1'b1;
    step();
    load_start = 1'b0;
    chk("restart_wc", 32'(word_count), 0);
    chk("restart_loaded", 32'(loaded), 0);
    in_valid = 1'b1; in_class = 3'd0; in_func = 3'd6;
    step();
    in_valid = 1'b0;
    chk("func6_err", 32'(err_illegal), 1);
    chk("func6_we", 32'(imem_we), 0);
    step();
    chk("func6_err_once", 32'(err_illegal), 0);
    chk("func6_wc", 32'(word_count), 0);

    in_valid = 1'b1; in_class = 3'd7;
    in_rs = 5'd1; in_rt = 5'd2; in_imm = 16'hFFFF;
    step();
    in_valid = 1'b0;
`ifdef ENC_ORI_BNE_EN
    chk("bne_we", 32'(imem_we), 1);
    chk("bne_wd", imem_wd, 32'h1422FFFF);
    chk("bne_err", 32'(err_illegal), 0);
    step();
    chk("bne_wc", 32'(word_count), 1);
`else
    chk("cls7_we", 32'(imem_we), 0);
    chk("cls7_err", 32'(err_illegal), 1);
    step();
    chk("cls7_err_once", 32'(err_illegal), 0);
    chk("cls7_wc", 32'(word_count), 0);
`endif

    load_start = 1'b1;
    step();
    load_start = 1'b0;
    in_valid = 1'b1; in_class = 3'd4;
    in_rs = 5'd1; in_rt = 5'd2; in_imm = 16'h0005;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("fill_we", 32'(imem_we), 1);
      chk("fill_addr", 32'(imem_addr), i);
      chk("fill_wd", imem_wd, 32'h20220005);
      chk("fill_full", 32'(full), (i == 3) ? 1 : 0);
    end
    chk("fill_ready", 32'(in_ready), 0);
    step();
    chk("fill_done", 32'(loaded), 1);
    chk("fill_wc", 32'(word_count), 4);
    chk("fill_no5th", 32'(imem_we), 0);
    step();
    chk("fill_stay", 32'(imem_we), 0);
    chk("fill_wc_hold", 32'(word_count), 4);

    load_start = 1'b1;
    step();
    load_start = 1'b0;
    chk("rs_full_clr", 32'(full), 0);
    in_imm = 16'h0001;
    step();
    in_imm = 16'h0002;
    step();
    in_imm = 16'h0003;
    step();
    chk("rs_pend_addr", 32'(imem_addr), 2);
    chk("rs_pend_wd", imem_wd, 32'h20220003);
    in_imm = 16'h0004;
    load_start = 1'b1;
    #1;
    chk("rs_ready", 32'(in_ready), 0);
    chk("rs_pend_we", 32'(imem_we), 1);
    step();
    load_start = 1'b0;
    chk("rs_no_xfer", 32'(imem_we), 0);
    chk("rs_wc0", 32'(word_count), 0);
    step();
    in_valid = 1'b0;
    chk("rs_base_we", 32'(imem_we), 1);
    chk("rs_base_addr", 32'(imem_addr), 0);
    chk("rs_base_wd", imem_wd, 32'h20220004);
    step();
    chk("rs_wc1", 32'(word_count), 1);

    in_valid = 1'b1;
    step();
    chk("ar_we_before", 32'(imem_we), 1);
    reset = 1'b1;
    #1;
    chk("ar_we", 32'(imem_we), 0);
    chk("ar_ready", 32'(in_ready), 0);
    chk("ar_wc", 32'(word_count), 0);
    in_valid = 1'b0;
    step();
    chk("ar_hold_we", 32'(imem_we), 0);
    chk("ar_loaded", 32'(loaded), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
